// File: rtl/uart_debug_pkg.sv
`default_nettype none
// ==== uart_debug_pkg : command codes, frame states and baud divider shared by the UART debug bridges (rev 1.0) ====
package uart_debug_pkg;

    typedef enum logic [7:0] {
        CMD_NOP   = 8'h00,
        CMD_READ  = 8'h01,
        CMD_WRITE = 8'h02,
        CMD_RST_A = 8'hFE,
        CMD_RST_D = 8'hFF
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_RESP,
        ST_DONE
    } state_t;

    // Bit period in clk cycles minus one, clk given in MHz.
    function automatic logic [31:0] calc_div(input int clk_mhz, input int baud);
        return 32'((clk_mhz * 1000000) / baud - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_core.sv
`default_nettype none
// ==== uart_core : 8N1/8N2 UART with valid/ready byte interface (rev 1.0) ====
module uart_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cfg_div,
    input  logic        cfg_txen,
    input  logic        cfg_rxen,
    input  logic        cfg_nstop,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    output logic        txd,
    input  logic        rxd
);
    logic        tx_busy;
    logic [15:0] tx_baud;
    logic [3:0]  tx_bitcnt;
    logic [9:0]  tx_shift;

    logic [1:0]  rxd_sync;
    logic        rx_busy;
    logic [15:0] rx_baud;
    logic [3:0]  rx_bitcnt;
    logic [7:0]  rx_shift;

    assign tx_ready = cfg_txen && !tx_busy;
    assign txd      = tx_busy ? tx_shift[0] : 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_busy   <= 1'b0;
            tx_baud   <= '0;
            tx_bitcnt <= '0;
            tx_shift  <= '1;
        end else if (!tx_busy) begin
            if (tx_valid && tx_ready) begin
                tx_shift  <= {1'b1, tx_data, 1'b0};
                tx_bitcnt <= cfg_nstop ? 4'd11 : 4'd10;
                tx_baud   <= cfg_div;
                tx_busy   <= 1'b1;
            end
        end else if (tx_baud != '0) begin
            tx_baud <= tx_baud - 1'b1;
        end else begin
            // Ones shift in behind the frame, so the optional second stop bit is free.
            tx_baud   <= cfg_div;
            tx_shift  <= {1'b1, tx_shift[9:1]};
            tx_bitcnt <= tx_bitcnt - 1'b1;
            if (tx_bitcnt == 4'd1) tx_busy <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rxd_sync  <= 2'b11;
            rx_busy   <= 1'b0;
            rx_baud   <= '0;
            rx_bitcnt <= '0;
            rx_shift  <= '0;
            rx_valid  <= 1'b0;
            rx_data   <= '0;
        end else begin
            rxd_sync <= {rxd_sync[0], rxd};
            rx_valid <= 1'b0;
            if (!rx_busy) begin
                if (cfg_rxen && !rxd_sync[1]) begin
                    rx_busy   <= 1'b1;
                    rx_baud   <= cfg_div >> 1;
                    rx_bitcnt <= '0;
                end
            end else if (rx_baud != '0) begin
                rx_baud <= rx_baud - 1'b1;
            end else begin
                rx_baud   <= cfg_div;
                rx_bitcnt <= rx_bitcnt + 1'b1;
                if (rx_bitcnt == 4'd0 && rxd_sync[1]) begin
                    rx_busy <= 1'b0;    // start bit did not survive to mid-bit: glitch
                end else if (rx_bitcnt == 4'd9) begin
                    rx_busy  <= 1'b0;
                    rx_valid <= rxd_sync[1];
                    rx_data  <= rx_shift;
                end else if (rx_bitcnt != 4'd0) begin
                    rx_shift <= {rxd_sync[1], rx_shift[7:1]};
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb2uart.sv
`default_nettype none
// ==== wb2uart : Wishbone B4 pipelined slave serialising bus accesses into UART debug frames (rev 1.0) ====
module wb2uart
    import uart_debug_pkg::*;
#(
    parameter int ADDR_BYTE   = 2,
    parameter int DATA_BYTE   = 2,
    parameter int BAUD_RATE   = 115200,
    parameter int CLK_FREQ    = 100,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int AW          = 8 * ADDR_BYTE,
    parameter int DW          = 8 * DATA_BYTE
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    output logic          uart_txd,
    input  logic          uart_rxd,
    input  logic          rst_a_req,
    input  logic          rst_d_req,
    output logic          busy,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic          wb_we_i,
    input  logic [AW-1:0] wb_adr_i,
    input  logic [DW-1:0] wb_dat_i,
    output logic [DW-1:0] wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          wb_stall_o
);
    localparam int            MAXB   = (ADDR_BYTE > DATA_BYTE) ? ADDR_BYTE : DATA_BYTE;
    localparam int            CW     = $clog2(MAXB + 1);
    localparam int            TW     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] A_LAST = CW'(ADDR_BYTE - 1);
    localparam logic [CW-1:0] D_LAST = CW'(DATA_BYTE - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [31:0]   DIV    = calc_div(CLK_FREQ, BAUD_RATE);

    state_t        state, state_nx;
    cmd_t          cmd;
    logic          we_q;
    logic [AW-1:0] adr_sh;
    logic [DW-1:0] dat_sh;
    logic [DW-1:0] rx_sh, rx_next;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tmo;
    logic          tmo_err;
    logic          pend_a, pend_d;
    logic          tx_valid, tx_ready, rx_valid;
    logic [7:0]    tx_data, rx_data;
    logic          accept, hs, is_rst;

    assign wb_stall_o = (state != ST_IDLE);
    assign accept     = wb_cyc_i && wb_stb_i && !wb_stall_o;
    assign hs         = tx_valid && tx_ready;
    assign is_rst     = (cmd == CMD_RST_A) || (cmd == CMD_RST_D);
    assign busy       = (state != ST_IDLE) || pend_a || pend_d;
    assign wb_ack_o   = (state == ST_DONE) && !tmo_err;
    assign wb_err_o   = (state == ST_DONE) && tmo_err;
    assign wb_dat_o   = (state == ST_DONE && !we_q && !tmo_err) ? rx_sh : '0;

    // Response bytes arrive LSB first, so each one enters at the top.
    generate
        if (DW > 8) begin : g_rx_wide
            assign rx_next = {rx_data, rx_sh[DW-1:8]};
        end else begin : g_rx_narrow
            assign rx_next = rx_data;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state)
            ST_IDLE: if (accept || pend_a || pend_d) state_nx = ST_CMD;
            ST_CMD: begin
                tx_valid = 1'b1;
                tx_data  = cmd;
                if (tx_ready) state_nx = is_rst ? ST_IDLE : ST_ADDR;
            end
            ST_ADDR: begin
                tx_valid = 1'b1;
                tx_data  = adr_sh[7:0];
                if (tx_ready && cnt == A_LAST) state_nx = we_q ? ST_DATA : ST_RESP;
            end
            ST_DATA: begin
                tx_valid = 1'b1;
                tx_data  = dat_sh[7:0];
                if (tx_ready && cnt == D_LAST) state_nx = ST_DONE;
            end
            ST_RESP: if ((rx_valid && cnt == D_LAST) || tmo == T_LAST) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd     <= CMD_NOP;
            we_q    <= 1'b0;
            adr_sh  <= '0;
            dat_sh  <= '0;
            rx_sh   <= '0;
            cnt     <= '0;
            tmo     <= '0;
            tmo_err <= 1'b0;
            pend_a  <= 1'b0;
            pend_d  <= 1'b0;
        end else begin
            // Bus request wins over pending remote-reset commands.
            if (state == ST_IDLE) begin
                if (accept) begin
                    cmd    <= wb_we_i ? CMD_WRITE : CMD_READ;
                    we_q   <= wb_we_i;
                    adr_sh <= wb_adr_i;
                    dat_sh <= wb_dat_i;
                    rx_sh  <= '0;
                end else if (pend_a) begin
                    cmd <= CMD_RST_A;
                end else if (pend_d) begin
                    cmd <= CMD_RST_D;
                end
            end
            if (state == ST_ADDR && hs) adr_sh <= adr_sh >> 8;
            if (state == ST_DATA && hs) dat_sh <= dat_sh >> 8;
            if (state == ST_RESP && rx_valid) rx_sh <= rx_next;

            if (state_nx != state)
                cnt <= '0;
            else if (((state == ST_ADDR || state == ST_DATA) && hs) || (state == ST_RESP && rx_valid))
                cnt <= cnt + 1'b1;

            if (state_nx != state || (state == ST_RESP && rx_valid))
                tmo <= '0;
            else if (state == ST_RESP)
                tmo <= tmo + 1'b1;

            // Only the value on the RESP exit cycle matters: set unless the final byte landed.
            if (state == ST_RESP)      tmo_err <= !(rx_valid && cnt == D_LAST);
            else if (state == ST_IDLE) tmo_err <= 1'b0;

            if (state == ST_CMD && hs && cmd == CMD_RST_A) pend_a <= 1'b0;
            if (state == ST_CMD && hs && cmd == CMD_RST_D) pend_d <= 1'b0;
            if (rst_a_req) pend_a <= 1'b1;
            if (rst_d_req) pend_d <= 1'b1;
        end
    end

    uart_core u_uart (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_div   (DIV[15:0]),
        .cfg_txen  (enable),
        .cfg_rxen  (enable),
        .cfg_nstop (1'b0),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .txd       (uart_txd),
        .rxd       (uart_rxd)
    );

endmodule
`default_nettype wire
